// File: rtl/div_iter_unit_pkg.sv
// Shared definitions for the iterative M-extension divider: op and state
// encodings plus small op-decoding helpers.
package div_iter_unit_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   localparam int WORD_W = 32;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_iter_unit_div_step.sv
// Combinational block of BITS_PER_CYCLE restoring division steps on {rem,quot}.
module div_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [XLEN:0]   rem_in,
   input  logic [XLEN-1:0] quot_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN:0]   rem_out,
   output logic [XLEN-1:0] quot_out
);

   // One extra remainder bit keeps the shifted partial remainder exact, so a
   // plain compare-and-subtract suffices and no final restore is needed.
   always_comb begin : steps
      logic [XLEN:0]   r;
      logic [XLEN-1:0] q;
      r = rem_in;
      q = quot_in;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r = {r[XLEN-1:0], q[XLEN-1]};
         q = {q[XLEN-2:0], 1'b0};
         if (r >= {1'b0, divisor}) begin
            r    = r - {1'b0, divisor};
            q[0] = 1'b1;
         end
      end
      rem_out  = r;
      quot_out = q;
   end

endmodule

// File: rtl/div_iter_unit.sv
// Iterative DIV/DIVU/REM/REMU divider (with RV64 W-forms) using valid/ready
// handshakes, optional leading-zero early-out, flush and a passthrough tag.
module div_iter_unit
   import div_iter_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int EARLY_OUT      = 1,
   parameter int TAG_W          = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       div_op,
   input  logic             is_word_op,
   input  logic [XLEN-1:0]  dividend,
   input  logic [XLEN-1:0]  divisor,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(XLEN + 1);
   localparam int              LOG_BPC  = $clog2(BITS_PER_CYCLE);
   localparam logic [CNT_W-1:0] RND_MASK = ~CNT_W'(BITS_PER_CYCLE - 1);
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   function automatic logic [XLEN-1:0] sext_word(input logic word, input logic [XLEN-1:0] v);
      logic [XLEN-1:0] o;
      o = v;
      if (word) begin
         for (int i = WORD_W; i < XLEN; i++) o[i] = v[WORD_W-1];
      end
      return o;
   endfunction

   div_state_e       state_q, state_d;
   div_op_e          op_in, op_q;
   logic             word_in, sgn_in, accept;
   logic [XLEN-1:0]  dvd_ext, dvs_ext, min_int, dvd_mag, dvs_mag;
   logic             dvd_neg, dvs_neg, dvs_zero, dvd_zero, ovf, fast;
   logic [XLEN-1:0]  fast_val, fix_val, rem_lo;
   logic [CNT_W-1:0] shift_amt, iter_cnt, cnt_q;
   logic [XLEN:0]    rem_q, step_rem;
   logic [XLEN-1:0]  quot_q, dvs_q, step_quot, result_q;
   logic             word_q, q_neg_q, r_neg_q;
   logic [TAG_W-1:0] tag_q;

   assign op_in  = div_op_e'(div_op);
   assign accept = in_valid && (state_q == S_IDLE) && !flush;

   // W-form operands are re-extended from bit 31 so the rest of the datapath
   // can treat every op as full-width; min_int and the checks follow suit.
   always_comb begin
      word_in = (XLEN > WORD_W) && is_word_op;
      sgn_in  = op_is_signed(op_in);
      dvd_ext = dividend;
      dvs_ext = divisor;
      min_int = '0;
      min_int[XLEN-1] = 1'b1;
      if (word_in) begin
         min_int[WORD_W-1] = 1'b1;
         for (int i = WORD_W; i < XLEN; i++) begin
            dvd_ext[i] = sgn_in & dividend[WORD_W-1];
            dvs_ext[i] = sgn_in & divisor[WORD_W-1];
            min_int[i] = 1'b1;
         end
      end
      dvd_neg  = sgn_in & dvd_ext[XLEN-1];
      dvs_neg  = sgn_in & dvs_ext[XLEN-1];
      dvd_mag  = dvd_neg ? -dvd_ext : dvd_ext;
      dvs_mag  = dvs_neg ? -dvs_ext : dvs_ext;
      dvs_zero = (dvs_ext == '0);
      dvd_zero = (dvd_ext == '0);
      ovf      = sgn_in && (dvd_ext == min_int) && (dvs_ext == ALL_ONES);
      fast     = dvs_zero || dvd_zero || ovf;
      fast_val = '0;
      if (dvs_zero)  fast_val = op_is_rem(op_in) ? dvd_ext : ALL_ONES;
      else if (ovf)  fast_val = op_is_rem(op_in) ? '0 : min_int;
   end

   // The dividend is aligned so its first live digit sits at the MSB; a W-form
   // magnitude already carries 32 zero upper bits, which the count absorbs.
   generate
      if (EARLY_OUT != 0) begin : g_early
         function automatic logic [CNT_W-1:0] lzc(input logic [XLEN-1:0] v);
            logic [CNT_W-1:0] n;
            logic             found;
            n     = '0;
            found = 1'b0;
            for (int i = XLEN - 1; i >= 0; i--) begin
               if (!found) begin
                  if (v[i]) found = 1'b1;
                  else      n = n + 1'b1;
               end
            end
            return n;
         endfunction
         assign shift_amt = lzc(dvd_mag) & RND_MASK;
      end else begin : g_fixed
         assign shift_amt = word_in ? CNT_W'(XLEN - WORD_W) : '0;
      end
   endgenerate

   assign iter_cnt = (CNT_W'(XLEN) - shift_amt) >> LOG_BPC;

   div_step #(
      .XLEN           (XLEN),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .rem_in   (rem_q),
      .quot_in  (quot_q),
      .divisor  (dvs_q),
      .rem_out  (step_rem),
      .quot_out (step_quot)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid) state_d = fast ? S_DONE : S_CALC;
         S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      rem_lo = rem_q[XLEN-1:0];
      if (op_is_rem(op_q)) fix_val = r_neg_q ? -rem_lo : rem_lo;
      else                 fix_val = q_neg_q ? -quot_q : quot_q;
   end

   // Fast-path results are produced at accept; iterative ones in FIX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= OP_DIV;
         word_q   <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         tag_q    <= '0;
      end else if (accept) begin
         op_q    <= op_in;
         word_q  <= word_in;
         q_neg_q <= dvd_neg ^ dvs_neg;
         r_neg_q <= dvd_neg;
         rem_q   <= '0;
         quot_q  <= dvd_mag << shift_amt;
         dvs_q   <= dvs_mag;
         cnt_q   <= iter_cnt;
         tag_q   <= in_tag;
         if (fast) result_q <= sext_word(word_in, fast_val);
      end else if (!flush) begin
         if (state_q == S_CALC) begin
            rem_q  <= step_rem;
            quot_q <= step_quot;
            cnt_q  <= cnt_q - 1'b1;
         end else if (state_q == S_FIX) begin
            result_q <= sext_word(word_q, fix_val);
         end
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign out_tag   = tag_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench: a 32-bit fixed-iteration divider and a 64-bit
// radix-4 early-out divider share one stimulus stream.
module tb_div_iter_unit;
   import div_iter_unit_pkg::*;

   logic        clk, reset, flush, in_valid, out_ready, is_word_op;
   logic [1:0]  div_op;
   logic [63:0] dividend, divisor;
   logic [4:0]  in_tag;
   logic        in_ready32, out_valid32, busy32;
   logic        in_ready64, out_valid64, busy64;
   logic [31:0] result32;
   logic [63:0] result64;
   logic [4:0]  out_tag32, out_tag64;
   logic        seen;
   int          checks, errors;

   div_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0), .TAG_W(5)) u32 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
      .div_op(div_op), .is_word_op(is_word_op), .dividend(dividend[31:0]),
      .divisor(divisor[31:0]), .in_tag(in_tag), .out_valid(out_valid32),
      .out_ready(out_ready), .result(result32), .out_tag(out_tag32), .busy(busy32));

   div_iter_unit #(.XLEN(64), .BITS_PER_CYCLE(2), .EARLY_OUT(1), .TAG_W(5)) u64 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .div_op(div_op), .is_word_op(is_word_op), .dividend(dividend),
      .divisor(divisor), .in_tag(in_tag), .out_valid(out_valid64),
      .out_ready(out_ready), .result(result64), .out_tag(out_tag64), .busy(busy64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic        word;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp32;
      logic [63:0] exp64;
      int          lat32;
      int          lat64;
   } vec_t;

   vec_t vecs[14];

   // Operands as the architecture sees them at effective width w.
   function automatic void getOps(input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] ua, output logic [63:0] ub,
                                  output logic signed [63:0] sa, output logic signed [63:0] sb,
                                  output logic [63:0] minv);
      if (w == 32) begin
         ua   = {32'b0, a[31:0]};
         ub   = {32'b0, b[31:0]};
         sa   = {{32{a[31]}}, a[31:0]};
         sb   = {{32{b[31]}}, b[31:0]};
         minv = 64'hFFFF_FFFF_8000_0000;
      end else begin
         ua   = a;
         ub   = b;
         sa   = a;
         sb   = b;
         minv = 64'h8000_0000_0000_0000;
      end
   endfunction

   function automatic logic [63:0] refDiv(input int xlen, input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
      int w;
      logic [63:0] ua, ub, minv, q, r, res;
      logic signed [63:0] sa, sb;
      logic sgn;
      w   = (xlen == 64 && word) ? 32 : xlen;
      sgn = (op == OP_DIV) || (op == OP_REM);
      getOps(w, a, b, ua, ub, sa, sb, minv);
      if (ub == 0) begin
         q = '1;
         r = sgn ? sa : ua;
      end else if (sgn && sa == minv && sb == -64'sd1) begin
         q = minv;
         r = 0;
      end else if (sgn) begin
         q = sa / sb;
         r = sa % sb;
      end else begin
         q = ua / ub;
         r = ua % ub;
      end
      res = (op == OP_REM || op == OP_REMU) ? r : q;
      if (xlen == 32)   res = {32'b0, res[31:0]};
      else if (w == 32) res = {{32{res[31]}}, res[31:0]};
      return res;
   endfunction

   function automatic int refLat(input int xlen, input int bpc, input bit eo, input logic [1:0] op,
                                 input logic word, input logic [63:0] a, input logic [63:0] b);
      int w, lz;
      logic [63:0] ua, ub, minv, mag;
      logic signed [63:0] sa, sb;
      logic sgn;
      w   = (xlen == 64 && word) ? 32 : xlen;
      sgn = (op == OP_DIV) || (op == OP_REM);
      getOps(w, a, b, ua, ub, sa, sb, minv);
      if (ub == 0 || ua == 0 || (sgn && sa == minv && sb == -64'sd1)) return 1;
      mag = (sgn && sa[63]) ? -sa : ua;
      lz  = 0;
      if (eo) begin
         for (int i = w - 1; i >= 0; i--) begin
            if (mag[i]) break;
            lz++;
         end
         lz = lz - (lz % bpc);
      end
      return (w - lz) / bpc + 2;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one op, then waits (bounded) for both units to show a result.
   task automatic applyStimulus(input logic [1:0] op, input logic word, input logic [63:0] a,
                                input logic [63:0] b, input logic [4:0] tag,
                                output int lat32, output int lat64);
      div_op = op; is_word_op = word; dividend = a; divisor = b; in_tag = tag;
      in_valid = 1'b1;
      lat32 = 0; lat64 = 0;
      for (int c = 1; c <= 200 && (lat32 == 0 || lat64 == 0); c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            in_valid = 1'b0;
            div_op   = 2'($urandom_range(0, 3));
            dividend = {$urandom, $urandom};
            divisor  = {$urandom, $urandom};
            in_tag   = 5'($urandom_range(0, 31));
         end
         if (lat32 == 0 && out_valid32) lat32 = c;
         if (lat64 == 0 && out_valid64) lat64 = c;
      end
   endtask

   task automatic retire(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({name, " idle"}, {60'b0, in_ready32, in_ready64, out_valid32, out_valid64}, 64'b1100);
   endtask

   task automatic runAndCheck(input string name, input logic [1:0] op, input logic word,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] exp32, input logic [63:0] exp64,
                              input int elat32, input int elat64);
      int l32, l64;
      logic [4:0] tag;
      tag = 5'($urandom_range(0, 31));
      applyStimulus(op, word, a, b, tag, l32, l64);
      checkOutput({name, " res32"}, {32'b0, result32}, exp32);
      checkOutput({name, " res64"}, result64, exp64);
      checkOutput({name, " tags"}, {54'b0, out_tag32, out_tag64}, {54'b0, tag, tag});
      checkOutput({name, " lat32"}, 64'(l32), 64'(elat32));
      checkOutput({name, " lat64"}, 64'(l64), 64'(elat64));
      retire(name);
   endtask

   initial begin
      int l32, l64;
      logic [1:0]  op;
      logic        word;
      logic [63:0] a, b;
      checks = 0; errors = 0;
      vecs[0]  = '{OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 34, 4};
      vecs[1]  = '{OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 34, 4};
      vecs[2]  = '{OP_DIVU, 1'b0, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
      vecs[3]  = '{OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 64'd5, 1, 1};
      vecs[4]  = '{OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1, 1};
      vecs[5]  = '{OP_REM,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 64'd0, 1, 1};
      vecs[6]  = '{OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 34, 18};
      vecs[7]  = '{OP_DIVU, 1'b0, 64'd3, 64'd1, 64'd3, 64'd3, 34, 3};
      vecs[8]  = '{OP_DIV,  1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1, 1};
      vecs[9]  = '{OP_REM,  1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 1};
      vecs[10] = '{OP_REMU, 1'b1, 64'h0000_0001_8000_0003, 64'd16, 64'd3, 64'd3, 34, 18};
      vecs[11] = '{OP_DIV,  1'b1, 64'h1234_5678_0000_0064, 64'hFFFF_FFF9, 64'hFFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFF2, 34, 6};
      vecs[12] = '{OP_REM,  1'b1, 64'hABCD_EF00_FFFF_FF9C, 64'd7, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 34, 6};
      vecs[13] = '{OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 1, 1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      div_op = 2'b00; is_word_op = 1'b0; dividend = '0; divisor = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("reset ready/busy", {60'b0, in_ready32, in_ready64, busy32, busy64}, 64'b1100);
      checkOutput("reset out_valid", {62'b0, out_valid32, out_valid64}, 64'b0);
      checkOutput("reset result", result64 | {32'b0, result32}, 64'b0);
      checkOutput("reset out_tag", {54'b0, out_tag32, out_tag64}, 64'b0);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++)
         runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b,
                     vecs[i].exp32, vecs[i].exp64, vecs[i].lat32, vecs[i].lat64);

      // Back-pressure: result and tag must hold while out_ready stays low.
      applyStimulus(OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, l32, l64);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("hold%0d u32", k), {26'b0, result32, out_tag32, out_valid32},
                     {26'b0, 32'hFFFF_FFFF, 5'd9, 1'b1});
         checkOutput($sformatf("hold%0d u64", k), result64, 64'hFFFF_FFFF_FFFF_FFFF);
         checkOutput($sformatf("hold%0d tag64", k), {58'b0, out_tag64, out_valid64}, {58'b0, 5'd9, 1'b1});
      end
      retire("hold");

      // Flush in the middle of CALC: no result may ever appear.
      div_op = OP_DIVU; is_word_op = 1'b0; dividend = '1; divisor = 64'd3; in_tag = 5'd5;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("busy before flush", {62'b0, busy32, busy64}, 64'b11);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush ready", {60'b0, in_ready32, in_ready64, busy32, busy64}, 64'b1100);
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen = seen | out_valid32 | out_valid64; end
      checkOutput("flush no out_valid", {63'b0, seen}, 64'b0);

      // Flush together with a request drops the request.
      div_op = OP_DIV; dividend = 64'd100; divisor = 64'd7; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      checkOutput("flush drops req", {60'b0, in_ready32, in_ready64, busy32, busy64}, 64'b1100);
      @(posedge clk); #1;
      checkOutput("flush drops out", {62'b0, out_valid32, out_valid64}, 64'b0);

      // Asynchronous reset mid-operation clears everything at once.
      runAndCheck("pre-reset", OP_DIV, 1'b0, 64'd77, 64'd7, 64'd11, 64'd11,
                  refLat(32, 1, 0, OP_DIV, 1'b0, 64'd77, 64'd7),
                  refLat(64, 2, 1, OP_DIV, 1'b0, 64'd77, 64'd7));
      div_op = OP_DIV; is_word_op = 1'b0; dividend = 64'd1000; divisor = 64'd3; in_tag = 5'd17;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      checkOutput("midreset state", {60'b0, in_ready32, in_ready64, busy32, busy64}, 64'b1100);
      checkOutput("midreset result", result64 | {32'b0, result32}, 64'b0);
      checkOutput("midreset tag/valid", {52'b0, out_tag32, out_tag64, out_valid32, out_valid64}, 64'b0);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Randomised ops against the arithmetic reference model.
      for (int n = 0; n < 40; n++) begin
         op   = 2'($urandom_range(0, 3));
         word = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       a = 64'd0;
            1:       a = 64'($urandom_range(1, 300));
            2:       a = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 5))
            0:       b = 64'd0;
            1:       b = '1;
            2:       b = 64'($urandom_range(1, 20));
            default: b = {$urandom, $urandom} >> $urandom_range(0, 60);
         endcase
         runAndCheck($sformatf("rnd%0d", n), op, word, a, b, refDiv(32, op, word, a, b),
                     refDiv(64, op, word, a, b), refLat(32, 1, 0, op, word, a, b),
                     refLat(64, 2, 1, op, word, a, b));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
